// File: rtl/clint_ctrl_if.sv
// CSR-file write port driven by the interrupt controller (CSR address/data/enable).
// The controller is the master; the CSR file is the slave.
interface clint_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 32
);
  logic              we;
  logic [CSR_AW-1:0] waddr;
  logic [CSR_AW-1:0] raddr;
  logic [XLEN-1:0]   data;

  modport master (output we, waddr, raddr, data);
  modport slave  (input  we, waddr, raddr, data);
endinterface

// File: rtl/clint_ctrl.sv
// Core-local interrupt controller: accepts ecall/ebreak/mret/async interrupts, holds the
// pipeline, sequences the mepc/mstatus/mcause writes and issues the fetch redirect.
module clint_ctrl #(
  parameter int XLEN   = 32,
  parameter int INT_W  = 8,
  parameter int CSR_AW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   inst,
  input  logic [XLEN-1:0]   inst_addr,
  input  logic              jump_flag,
  input  logic [XLEN-1:0]   jump_addr,
  input  logic [INT_W-1:0]  int_flag,
  input  logic [XLEN-1:0]   csr_mtvec,
  input  logic [XLEN-1:0]   csr_mepc,
  input  logic [XLEN-1:0]   csr_mstatus,
  input  logic              global_int_en,
  clint_ctrl_if.master      csr,
  output logic              hold_flag,
  output logic              int_assert,
  output logic [XLEN-1:0]   int_addr
);

  localparam logic [XLEN-1:0]   INST_ECALL  = XLEN'(32'h0000_0073);
  localparam logic [XLEN-1:0]   INST_EBREAK = XLEN'(32'h0010_0073);
  localparam logic [XLEN-1:0]   INST_MRET   = XLEN'(32'h3020_0073);
  localparam logic [XLEN-1:0]   CAUSE_ECALL  = XLEN'(32'd11);
  localparam logic [XLEN-1:0]   CAUSE_EBREAK = XLEN'(32'd3);
  localparam logic [XLEN-1:0]   CAUSE_TIMER  = XLEN'(32'h8000_0007);
  localparam logic [XLEN-1:0]   CAUSE_EXT    = XLEN'(32'h8000_000B);
  localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MSTATUS,
    S_W_MCAUSE,
    S_ASSERT,
    S_W_MRET,
    S_ASSERT_RET
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_q, cause_q;
  logic [XLEN-1:0] pc_nxt, cause_nxt;
  logic            cap_en;

  logic              we;
  logic [CSR_AW-1:0] waddr;
  logic [XLEN-1:0]   data;
  logic [XLEN-1:0]   mst_trap, mst_ret;

  // Requests are masked while reset is asserted so hold_flag cannot rise during reset.
  logic sync_req, mret_req, async_req;
  assign sync_req  = rst && ((inst == INST_ECALL) || (inst == INST_EBREAK));
  assign mret_req  = rst && (inst == INST_MRET);
  assign async_req = rst && global_int_en && (|int_flag);

  always_comb begin
    mst_trap    = csr_mstatus;
    mst_trap[7] = csr_mstatus[3];
    mst_trap[3] = 1'b0;
    mst_ret     = csr_mstatus;
    mst_ret[3]  = csr_mstatus[7];
    mst_ret[7]  = 1'b1;
  end

  // NOTE: every output of this block is assigned a default first; without that a
  // state that skips an assignment would infer a latch.
  always_comb begin
    state_nxt  = state;
    cap_en     = 1'b0;
    pc_nxt     = pc_q;
    cause_nxt  = cause_q;
    we         = 1'b0;
    waddr      = '0;
    data       = '0;
    hold_flag  = 1'b0;
    int_assert = 1'b0;
    int_addr   = '0;

    unique case (state)
      S_IDLE: begin
        if (sync_req) begin
          state_nxt = S_W_MEPC;
          hold_flag = 1'b1;
          cap_en    = 1'b1;
          pc_nxt    = inst_addr;
          cause_nxt = (inst == INST_ECALL) ? CAUSE_ECALL : CAUSE_EBREAK;
        end else if (mret_req) begin
          state_nxt = S_W_MRET;
          hold_flag = 1'b1;
        end else if (async_req) begin
          state_nxt = S_W_MEPC;
          hold_flag = 1'b1;
          cap_en    = 1'b1;
          // A taken branch in EX means inst_addr is on the wrong path; resume at the target.
          pc_nxt    = jump_flag ? jump_addr : inst_addr;
          cause_nxt = int_flag[0] ? CAUSE_TIMER : CAUSE_EXT;
        end
      end
      S_W_MEPC: begin
        state_nxt = S_W_MSTATUS;
        hold_flag = 1'b1;
        we        = 1'b1;
        waddr     = ADDR_MEPC;
        data      = pc_q;
      end
      S_W_MSTATUS: begin
        state_nxt = S_W_MCAUSE;
        hold_flag = 1'b1;
        we        = 1'b1;
        waddr     = ADDR_MSTATUS;
        data      = mst_trap;
      end
      S_W_MCAUSE: begin
        state_nxt = S_ASSERT;
        hold_flag = 1'b1;
        we        = 1'b1;
        waddr     = ADDR_MCAUSE;
        data      = cause_q;
      end
      S_ASSERT: begin
        state_nxt  = S_IDLE;
        hold_flag  = 1'b1;
        int_assert = 1'b1;
        int_addr   = csr_mtvec;
      end
      S_W_MRET: begin
        state_nxt = S_ASSERT_RET;
        hold_flag = 1'b1;
        we        = 1'b1;
        waddr     = ADDR_MSTATUS;
        data      = mst_ret;
      end
      S_ASSERT_RET: begin
        state_nxt  = S_IDLE;
        hold_flag  = 1'b1;
        int_assert = 1'b1;
        int_addr   = csr_mepc;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state <= state_nxt;
      if (cap_en) begin
        pc_q    <= pc_nxt;
        cause_q <= cause_nxt;
      end
    end
  end

  assign csr.we    = we;
  assign csr.waddr = waddr;
  assign csr.raddr = '0;
  assign csr.data  = data;

endmodule

// File: tb/tb_clint_ctrl.sv
// Self-checking bench for clint_ctrl: directed cases plus random transactions compared
// cycle by cycle against a transaction-level model of the trap/mret sequences.
module tb_clint_ctrl;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [31:0] data;
    logic        hold;
    logic        ia;
    logic [31:0] iaddr;
  } obs_t;

  logic        clk;
  logic        rst;
  logic [31:0] inst, inst_addr, jump_addr, csr_mtvec, csr_mepc, csr_mstatus;
  logic        jump_flag, global_int_en;
  logic [7:0]  int_flag;
  logic        hold_flag, int_assert;
  logic [31:0] int_addr;

  int n_cmp = 0;
  int n_bad = 0;

  clint_ctrl_if #(.XLEN(32), .CSR_AW(32)) csr_bus ();

  clint_ctrl #(.XLEN(32), .INT_W(8), .CSR_AW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst          (inst),
    .inst_addr     (inst_addr),
    .jump_flag     (jump_flag),
    .jump_addr     (jump_addr),
    .int_flag      (int_flag),
    .csr_mtvec     (csr_mtvec),
    .csr_mepc      (csr_mepc),
    .csr_mstatus   (csr_mstatus),
    .global_int_en (global_int_en),
    .csr           (csr_bus),
    .hold_flag     (hold_flag),
    .int_assert    (int_assert),
    .int_addr      (int_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(logic we, logic [31:0] wa, logic [31:0] d,
                              logic h, logic ia, logic [31:0] iaddr);
    obs_t o;
    o.we = we; o.waddr = wa; o.raddr = 32'h0; o.data = d;
    o.hold = h; o.ia = ia; o.iaddr = iaddr;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t got;
    got = mk(csr_bus.we, csr_bus.waddr, csr_bus.data, hold_flag, int_assert, int_addr);
    got.raddr = csr_bus.raddr;
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed we=%b waddr=%h raddr=%h data=%h hold=%b ia=%b iaddr=%h / expected we=%b waddr=%h raddr=%h data=%h hold=%b ia=%b iaddr=%h",
             tag, got.we, got.waddr, got.raddr, got.data, got.hold, got.ia, got.iaddr,
             exp.we, exp.waddr, exp.raddr, exp.data, exp.hold, exp.ia, exp.iaddr);
    end
  endtask

  // Reference model: expected per-cycle outputs of one transaction, starting at the
  // cycle the request is presented in IDLE.
  task automatic build_expect(input logic [31:0] t_inst, t_iaddr, input logic t_jf,
                              input logic [31:0] t_ja, input logic [7:0] t_int,
                              input logic t_mie, input logic [31:0] t_mtvec, t_mepc, t_mst,
                              output obs_t q[$]);
    logic [31:0] pc, cause, m;
    int kind;
    q = {};
    kind = 0;
    pc = 0;
    cause = 0;
    if (t_inst == ECALL || t_inst == EBREAK) begin
      kind = 1; pc = t_iaddr; cause = (t_inst == ECALL) ? 32'd11 : 32'd3;
    end else if (t_inst == MRET) begin
      kind = 2;
    end else if (t_mie && t_int != 8'h0) begin
      kind = 1; pc = t_jf ? t_ja : t_iaddr;
      cause = t_int[0] ? 32'h8000_0007 : 32'h8000_000B;
    end
    if (kind == 0) begin
      q.push_back(mk(0, 0, 0, 0, 0, 0));
    end else if (kind == 1) begin
      m = t_mst; m[7] = t_mst[3]; m[3] = 1'b0;
      q.push_back(mk(0, 0, 0, 1, 0, 0));
      q.push_back(mk(1, 32'h341, pc, 1, 0, 0));
      q.push_back(mk(1, 32'h300, m, 1, 0, 0));
      q.push_back(mk(1, 32'h342, cause, 1, 0, 0));
      q.push_back(mk(0, 0, 0, 1, 1, t_mtvec));
    end else begin
      m = t_mst; m[3] = t_mst[7]; m[7] = 1'b1;
      q.push_back(mk(0, 0, 0, 1, 0, 0));
      q.push_back(mk(1, 32'h300, m, 1, 0, 0));
      q.push_back(mk(0, 0, 0, 1, 1, t_mepc));
    end
  endtask

  // Called at posedge+1; presents the request, then noise or NOPs while busy.
  task automatic run_txn(input string tag, input logic [31:0] t_inst, t_iaddr,
                         input logic t_jf, input logic [31:0] t_ja, input logic [7:0] t_int,
                         input logic t_mie, input logic [31:0] t_mtvec, t_mepc, t_mst,
                         input logic noise);
    obs_t q[$];
    build_expect(t_inst, t_iaddr, t_jf, t_ja, t_int, t_mie, t_mtvec, t_mepc, t_mst, q);
    csr_mtvec = t_mtvec; csr_mepc = t_mepc; csr_mstatus = t_mst; global_int_en = t_mie;
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0) begin
        inst = t_inst; inst_addr = t_iaddr; jump_flag = t_jf; jump_addr = t_ja; int_flag = t_int;
      end else if (noise) begin
        case ($urandom_range(0, 3))
          0: inst = ECALL;
          1: inst = EBREAK;
          2: inst = MRET;
          default: inst = NOP;
        endcase
        inst_addr = $urandom; jump_flag = 1'($urandom_range(0, 1));
        jump_addr = $urandom; int_flag = 8'($urandom);
      end else begin
        inst = NOP; int_flag = 8'h0; jump_flag = 1'b0;
      end
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), q[i]);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] r_inst, r_mst;
    logic [7:0]  r_int;

    rst = 1'b0;
    inst = ECALL; inst_addr = 32'h100; jump_flag = 1'b0; jump_addr = 32'h0;
    int_flag = 8'hFF; csr_mtvec = 32'h200; csr_mepc = 32'h0; csr_mstatus = 32'h8;
    global_int_en = 1'b1;
    @(negedge clk);
    check("reset_idle", mk(0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b1;

    run_txn("ecall",     ECALL, 32'h100, 0, 32'h0,  8'h00, 1, 32'h200, 32'h0,   32'h8,  0);
    run_txn("async_tmr", NOP,   32'h40,  1, 32'h80, 8'h01, 1, 32'h200, 32'h0,   32'h8,  0);
    run_txn("mie_off0",  NOP,   32'h44,  0, 32'h0,  8'h02, 0, 32'h200, 32'h0,   32'h0,  0);
    run_txn("mie_off1",  NOP,   32'h48,  0, 32'h0,  8'h02, 0, 32'h200, 32'h0,   32'h0,  0);
    run_txn("mret",      MRET,  32'h300, 0, 32'h0,  8'h00, 0, 32'h200, 32'h104, 32'h80, 0);
    run_txn("ebrk_int",  EBREAK,32'h50,  0, 32'h0,  8'h01, 1, 32'h200, 32'h0,   32'h8,  1);
    run_txn("async_ext", NOP,   32'h60,  0, 32'h90, 8'h04, 1, 32'h280, 32'h0,   32'h8,  1);
    run_txn("ecall_int", ECALL, 32'h70,  1, 32'h99, 8'h03, 1, 32'h200, 32'h0,   32'h88, 1);

    // Reset landing in W_MSTATUS aborts the sequence immediately.
    csr_mtvec = 32'h400; csr_mstatus = 32'h8; global_int_en = 1'b1;
    inst = ECALL; inst_addr = 32'h300; int_flag = 8'h0;
    @(negedge clk); check("rstmid_acc", mk(0, 0, 0, 1, 0, 0));
    @(posedge clk); #1; inst = NOP;
    @(negedge clk); check("rstmid_mepc", mk(1, 32'h341, 32'h300, 1, 0, 0));
    @(posedge clk); #1;
    @(negedge clk); check("rstmid_mst", mk(1, 32'h300, 32'h80, 1, 0, 0));
    #1 rst = 1'b0; inst = ECALL;
    #1 check("rstmid_now", mk(0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("rstmid_held", mk(0, 0, 0, 0, 0, 0));
    rst = 1'b1; inst = NOP;
    @(negedge clk); check("rstmid_idle", mk(0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    run_txn("after_rst", ECALL, 32'h500, 0, 32'h0, 8'h00, 1, 32'h600, 32'h0, 32'h8, 0);

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 4))
        0: r_inst = ECALL;
        1: r_inst = EBREAK;
        2: r_inst = MRET;
        3: r_inst = NOP;
        default: r_inst = $urandom;
      endcase
      r_int = ($urandom_range(0, 2) == 0) ? 8'h0 : 8'($urandom);
      r_mst = $urandom;
      run_txn($sformatf("rnd%0d", t), r_inst, $urandom & 32'hFFFF_FFFC,
              1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, r_int, r_mst[3],
              $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, r_mst,
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
